mem_access_sequencer: RTL and testbench

- Multicycle FSM that owns the shared instruction/data memory port of the MIPS datapath.
- Arbitrates between instruction fetch, data load/store and exception-vector fetch requests.
- Drives the 2-bit IorD address-mux select and the memory write strobe.
- Counts memory wait states and returns a one-cycle done pulse to the winning requester.

---
 rtl/mem_access_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Multicycle memory-port sequencer: arbitrates fetch/data/exception requests and times each access.
// Optional per-class completion counters are compiled in when MEM_SEQ_STATS_EN is defined.
module mem_access_sequencer #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       data_rd_req,
  input  logic       data_wr_req,
  input  logic       exc_req,
  input  logic       exc_sel,
  output logic [1:0] i_or_d,
  output logic       mem_wr,
  output logic       mdr_load,
  output logic       done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       proto_err
`ifdef MEM_SEQ_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] data_cnt,
  output logic [15:0] exc_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

  localparam logic [1:0]       GRANT_FETCH = 2'd0;
  localparam logic [1:0]       GRANT_DATA  = 2'd1;
  localparam logic [1:0]       GRANT_EXC   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       i_or_d_q, i_or_d_d;
  logic [1:0]       grant_q, grant_d;
  logic             wr_q, wr_d;
  logic             mem_wr_q, mem_wr_d;
  logic             mdr_load_q, mdr_load_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             proto_err_q, proto_err_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      i_or_d_q    <= 2'd0;
      grant_q     <= 2'd0;
      wr_q        <= 1'b0;
      mem_wr_q    <= 1'b0;
      mdr_load_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_or_d_q    <= i_or_d_d;
      grant_q     <= grant_d;
      wr_q        <= wr_d;
      mem_wr_q    <= mem_wr_d;
      mdr_load_q  <= mdr_load_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next state plus next values of the registered outputs; pulses default low
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_or_d_d    = i_or_d_q;
    grant_d     = grant_q;
    wr_d        = wr_q;
    busy_d      = busy_q;
    proto_err_d = proto_err_q;
    mem_wr_d    = 1'b0;
    mdr_load_d  = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (data_rd_req && data_wr_req) begin
          proto_err_d = 1'b1;
        end
        if (exc_req || data_wr_req || data_rd_req || fetch_req) begin
          state_d = S_ACCESS;
          busy_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          if (exc_req) begin
            grant_d  = GRANT_EXC;
            i_or_d_d = {1'b1, exc_sel};
            wr_d     = 1'b0;
          end else if (data_wr_req) begin
            grant_d  = GRANT_DATA;
            i_or_d_d = 2'd1;
            wr_d     = 1'b1;
            mem_wr_d = 1'b1;
          end else if (data_rd_req) begin
            grant_d  = GRANT_DATA;
            i_or_d_d = 2'd1;
            wr_d     = 1'b0;
          end else begin
            grant_d  = GRANT_FETCH;
            i_or_d_d = 2'd0;
            wr_d     = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        if (MEM_LATENCY > 1) begin
          state_d = S_WAIT;
        end else begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          mdr_load_d = ~wr_q;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          mdr_load_d = ~wr_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign i_or_d    = i_or_d_q;
  assign mem_wr    = mem_wr_q;
  assign mdr_load  = mdr_load_q;
  assign done      = done_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign proto_err = proto_err_q;

`ifdef MEM_SEQ_STATS_EN
  logic [15:0] fetch_cnt_q, data_cnt_q, exc_cnt_q;

  // Saturating per-class completion counters, bumped while in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 16'd0;
      data_cnt_q  <= 16'd0;
      exc_cnt_q   <= 16'd0;
    end else if (state_q == S_DONE) begin
      if (grant_q == GRANT_FETCH && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (grant_q == GRANT_DATA  && data_cnt_q  != 16'hFFFF) data_cnt_q  <= data_cnt_q + 16'd1;
      if (grant_q == GRANT_EXC   && exc_cnt_q   != 16'hFFFF) exc_cnt_q   <= exc_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign data_cnt  = data_cnt_q;
  assign exc_cnt   = exc_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1.
`timescale 1ns/1ps
module tb_mem_access_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic fetch_req, data_rd_req, data_wr_req, exc_req, exc_sel;
  logic [1:0] i_or_d, grant;
  logic mem_wr, mdr_load, done, busy, proto_err;

  logic fetch2, rd2, wr2, exc2;
  logic [1:0] i_or_d2, grant2;
  logic mem_wr2, mdr_load2, done2, busy2, proto_err2;

`ifdef MEM_SEQ_STATS_EN
  logic [15:0] fetch_cnt, data_cnt, exc_cnt;
  logic [15:0] fetch_cnt2, data_cnt2, exc_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Observation vector: i_or_d, grant, busy, mem_wr, mdr_load, done, proto_err
  wire [8:0] obs  = {i_or_d, grant, busy, mem_wr, mdr_load, done, proto_err};
  wire [8:0] obs2 = {i_or_d2, grant2, busy2, mem_wr2, mdr_load2, done2, proto_err2};

  mem_access_sequencer #(.MEM_LATENCY(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
    .exc_req(exc_req), .exc_sel(exc_sel),
    .i_or_d(i_or_d), .mem_wr(mem_wr), .mdr_load(mdr_load), .done(done),
    .grant(grant), .busy(busy), .proto_err(proto_err)
`ifdef MEM_SEQ_STATS_EN
    , .fetch_cnt(fetch_cnt), .data_cnt(data_cnt), .exc_cnt(exc_cnt)
`endif
  );

  mem_access_sequencer #(.MEM_LATENCY(1), .CNT_W(4)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch2), .data_rd_req(rd2), .data_wr_req(wr2),
    .exc_req(exc2), .exc_sel(1'b0),
    .i_or_d(i_or_d2), .mem_wr(mem_wr2), .mdr_load(mdr_load2), .done(done2),
    .grant(grant2), .busy(busy2), .proto_err(proto_err2)
`ifdef MEM_SEQ_STATS_EN
    , .fetch_cnt(fetch_cnt2), .data_cnt(data_cnt2), .exc_cnt(exc_cnt2)
`endif
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_req = 0; data_rd_req = 0; data_wr_req = 0; exc_req = 0; exc_sel = 0;
    fetch2 = 0; rd2 = 0; wr2 = 0; exc2 = 0;
    step(); step();
    checks++; if (obs !== 9'd0) begin errors++; $display("FAIL reset_l2 got %b want %b", obs, 9'd0); end
    checks++; if (obs2 !== 9'd0) begin errors++; $display("FAIL reset_l1 got %b want %b", obs2, 9'd0); end
    reset = 1'b0;
    step();
    checks++; if (obs !== 9'd0) begin errors++; $display("FAIL idle_after_reset got %b want %b", obs, 9'd0); end
  endtask

  task automatic test_fetch();
    fetch_req = 1; step();
    checks++; if (obs !== {2'd0, 2'd0, 5'b10000}) begin errors++; $display("FAIL fetch_access got %b want %b", obs, {2'd0, 2'd0, 5'b10000}); end
    fetch_req = 0; step();
    checks++; if (obs !== {2'd0, 2'd0, 5'b10000}) begin errors++; $display("FAIL fetch_wait got %b want %b", obs, {2'd0, 2'd0, 5'b10000}); end
    step();
    checks++; if (obs !== {2'd0, 2'd0, 5'b10110}) begin errors++; $display("FAIL fetch_done got %b want %b", obs, {2'd0, 2'd0, 5'b10110}); end
    step();
    checks++; if (obs !== 9'd0) begin errors++; $display("FAIL fetch_idle got %b want %b", obs, 9'd0); end
  endtask

  task automatic test_store_over_fetch();
    data_wr_req = 1; fetch_req = 1; step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b11000}) begin errors++; $display("FAIL store_access got %b want %b", obs, {2'd1, 2'd1, 5'b11000}); end
    data_wr_req = 0; step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b10000}) begin errors++; $display("FAIL store_wait got %b want %b", obs, {2'd1, 2'd1, 5'b10000}); end
    step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b10010}) begin errors++; $display("FAIL store_done got %b want %b", obs, {2'd1, 2'd1, 5'b10010}); end
    step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b00000}) begin errors++; $display("FAIL store_idle_hold got %b want %b", obs, {2'd1, 2'd1, 5'b00000}); end
    step();
    checks++; if (obs !== {2'd0, 2'd0, 5'b10000}) begin errors++; $display("FAIL queued_fetch_access got %b want %b", obs, {2'd0, 2'd0, 5'b10000}); end
    fetch_req = 0; step(); step();
    checks++; if (obs !== {2'd0, 2'd0, 5'b10110}) begin errors++; $display("FAIL queued_fetch_done got %b want %b", obs, {2'd0, 2'd0, 5'b10110}); end
    step();
  endtask

  task automatic test_exc_no_preempt();
    data_rd_req = 1; step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b10000}) begin errors++; $display("FAIL load_access got %b want %b", obs, {2'd1, 2'd1, 5'b10000}); end
    data_rd_req = 0; step();
    exc_req = 1; exc_sel = 1; step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b10110}) begin errors++; $display("FAIL load_done_under_exc got %b want %b", obs, {2'd1, 2'd1, 5'b10110}); end
    step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b00000}) begin errors++; $display("FAIL load_idle got %b want %b", obs, {2'd1, 2'd1, 5'b00000}); end
    step();
    checks++; if (obs !== {2'd3, 2'd2, 5'b10000}) begin errors++; $display("FAIL exc_access got %b want %b", obs, {2'd3, 2'd2, 5'b10000}); end
    exc_req = 0; exc_sel = 0; step(); step();
    checks++; if (obs !== {2'd3, 2'd2, 5'b10110}) begin errors++; $display("FAIL exc_done got %b want %b", obs, {2'd3, 2'd2, 5'b10110}); end
    step();
    checks++; if (obs !== {2'd3, 2'd2, 5'b00000}) begin errors++; $display("FAIL exc_idle_hold got %b want %b", obs, {2'd3, 2'd2, 5'b00000}); end
  endtask

  task automatic test_proto_err();
    data_rd_req = 1; data_wr_req = 1; step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b11001}) begin errors++; $display("FAIL conflict_access got %b want %b", obs, {2'd1, 2'd1, 5'b11001}); end
    data_rd_req = 0; data_wr_req = 0; step(); step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b10011}) begin errors++; $display("FAIL conflict_done got %b want %b", obs, {2'd1, 2'd1, 5'b10011}); end
    step();
    fetch_req = 1; step();
    fetch_req = 0; step(); step();
    checks++; if (obs !== {2'd0, 2'd0, 5'b10111}) begin errors++; $display("FAIL sticky_err_fetch_done got %b want %b", obs, {2'd0, 2'd0, 5'b10111}); end
    step();
    reset = 1; step();
    checks++; if (obs !== 9'd0) begin errors++; $display("FAIL err_cleared_by_reset got %b want %b", obs, 9'd0); end
    reset = 0; step();
  endtask

  task automatic test_reset_mid_store();
    data_wr_req = 1; step();
    data_wr_req = 0; step();
    checks++; if (obs !== {2'd1, 2'd1, 5'b10000}) begin errors++; $display("FAIL abort_store_wait got %b want %b", obs, {2'd1, 2'd1, 5'b10000}); end
    reset = 1; step();
    checks++; if (obs !== 9'd0) begin errors++; $display("FAIL abort_reset_outputs got %b want %b", obs, 9'd0); end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (obs !== 9'd0) begin errors++; $display("FAIL abort_no_done cycle %0d got %b want %b", i, obs, 9'd0); end
    end
  endtask

  task automatic test_latency_one();
    fetch2 = 1; step();
    checks++; if (obs2 !== {2'd0, 2'd0, 5'b10000}) begin errors++; $display("FAIL l1_fetch_access got %b want %b", obs2, {2'd0, 2'd0, 5'b10000}); end
    fetch2 = 0; step();
    checks++; if (obs2 !== {2'd0, 2'd0, 5'b10110}) begin errors++; $display("FAIL l1_fetch_done got %b want %b", obs2, {2'd0, 2'd0, 5'b10110}); end
    step();
    checks++; if (obs2 !== 9'd0) begin errors++; $display("FAIL l1_fetch_idle got %b want %b", obs2, 9'd0); end
    wr2 = 1; step();
    checks++; if (obs2 !== {2'd1, 2'd1, 5'b11000}) begin errors++; $display("FAIL l1_store_access got %b want %b", obs2, {2'd1, 2'd1, 5'b11000}); end
    wr2 = 0; step();
    checks++; if (obs2 !== {2'd1, 2'd1, 5'b10010}) begin errors++; $display("FAIL l1_store_done got %b want %b", obs2, {2'd1, 2'd1, 5'b10010}); end
    step();
    checks++; if (obs2 !== {2'd1, 2'd1, 5'b00000}) begin errors++; $display("FAIL l1_store_idle got %b want %b", obs2, {2'd1, 2'd1, 5'b00000}); end
  endtask

`ifdef MEM_SEQ_STATS_EN
  task automatic test_stats();
    reset = 1; step(); reset = 0; step();
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1; step(); fetch_req = 0; step(); step(); step();
    end
    data_rd_req = 1; step(); data_rd_req = 0; step(); step(); step();
    checks++; if (fetch_cnt !== 16'd3) begin errors++; $display("FAIL stats_fetch got %0d want 3", fetch_cnt); end
    checks++; if (data_cnt !== 16'd1) begin errors++; $display("FAIL stats_data got %0d want 1", data_cnt); end
    checks++; if (exc_cnt !== 16'd0) begin errors++; $display("FAIL stats_exc got %0d want 0", exc_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store_over_fetch();
    test_exc_no_preempt();
    test_proto_err();
    test_reset_mid_store();
    test_latency_one();
`ifdef MEM_SEQ_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
